bram_sdp_read_streamer: RTL and testbench

//  Read-side engine for a simple-dual-port block RAM built from bram_primitive.

---
 rtl/bram_sdp_read_streamer_pkg.sv | 21 ++
 rtl/bram_sdp_read_streamer_skid_fifo.sv | 59 +++++
 rtl/bram_sdp_read_streamer.sv | 163 ++++++++++++++++
 tb/tb_bram_sdp_read_streamer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_sdp_read_streamer_pkg.sv
// Shared definitions for the BRAM simple-dual-port read streamer.
package bram_sdp_read_streamer_pkg;

    // Read engine control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Landing FIFO depth; also the cap on issued-but-not-popped words.
    localparam int unsigned RD_FIFO_DEPTH = 4;
    // Counter width able to hold 0..RD_FIFO_DEPTH.
    localparam int unsigned RD_FIFO_CW    = 3;

    // RAM read latency in cycles for a given output-register setting.
    function automatic int unsigned rd_latency(input int unsigned output_reg);
        return (output_reg != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/bram_sdp_read_streamer_skid_fifo.sv
// Four-entry first-word-fall-through FIFO. The head entry is a register,
// so the read-side outputs come straight from flops.
module bram_sdp_read_streamer_skid_fifo
    import bram_sdp_read_streamer_pkg::*;
#(
    parameter int unsigned WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [WIDTH-1:0]      rd_data,
    output logic [RD_FIFO_CW-1:0] count
);

    localparam int unsigned DEPTH = RD_FIFO_DEPTH;
    localparam int unsigned IW    = $clog2(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [RD_FIFO_CW-1:0] count_q;
    logic [RD_FIFO_CW-1:0] count_d_c;
    logic                  valid_q;
    logic                  pop_c;
    logic [IW-1:0]         widx_c;

    assign pop_c     = rd_en & valid_q;
    assign count_d_c = count_q + RD_FIFO_CW'(wr_en) - RD_FIFO_CW'(pop_c);
    // A write lands just behind the surviving entries after this cycle's pop.
    assign widx_c    = IW'(count_q - RD_FIFO_CW'(pop_c));

    // Shift-on-pop storage with occupancy and valid tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (pop_c) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_q[i] <= mem_q[i+1];
                end
            end
            if (wr_en) begin
                mem_q[widx_c] <= wr_data;
            end
            count_q <= count_d_c;
            valid_q <= (count_d_c != '0);
        end
    end

    assign rd_valid = valid_q;
    assign rd_data  = mem_q[0];
    assign count    = count_q;

endmodule

// File: rtl/bram_sdp_read_streamer.sv
// Burst read engine for a simple-dual-port BRAM: issues reads, absorbs the
// RAM latency and presents the words as a valid/ready stream with LAST.
module bram_sdp_read_streamer
    import bram_sdp_read_streamer_pkg::*;
#(
    parameter int unsigned READ_DATA_WIDTH    = 16,
    parameter int unsigned READ_ADDRESS_WIDTH = 9,
    parameter int unsigned OUTPUT_REG         = 0,
    parameter int unsigned LEN_WIDTH          = 10
) (
    input  logic                          RCLK,
    input  logic                          RST,
    input  logic                          CMD_VALID,
    output logic                          CMD_READY,
    input  logic [READ_ADDRESS_WIDTH-1:0] CMD_ADDR,
    input  logic [LEN_WIDTH-1:0]          CMD_LEN,
    output logic                          RE,
    output logic                          RADDREN,
    output logic [READ_ADDRESS_WIDTH-1:0] RADDR,
    input  logic [READ_DATA_WIDTH-1:0]    RDATA,
    output logic                          M_VALID,
    input  logic                          M_READY,
    output logic [READ_DATA_WIDTH-1:0]    M_DATA,
    output logic                          M_LAST,
    output logic                          BUSY
);

    localparam int unsigned DW  = READ_DATA_WIDTH;
    localparam int unsigned AW  = READ_ADDRESS_WIDTH;
    localparam int unsigned LW  = LEN_WIDTH;
    localparam int unsigned LAT = rd_latency(OUTPUT_REG);
    localparam int unsigned CW  = RD_FIFO_CW;
    localparam int unsigned OW  = CW + 1;

    rd_state_e      state_q;
    logic           cmd_ready_q;
    logic           busy_q;
    logic           re_q;
    logic           last_q;
    logic [AW-1:0]  raddr_q;
    logic [LW-1:0]  rem_q;
    logic [CW-1:0]  inflight_q;
    logic [LAT-1:0] tag_vld_q;
    logic [LAT-1:0] tag_last_q;

    logic           fifo_valid;
    logic [DW:0]    fifo_head;
    logic [CW-1:0]  fifo_count;

    logic           accept_c;
    logic           pop_c;
    logic           land_c;
    logic [OW-1:0]  occ_c;
    logic           can_issue_c;

    assign accept_c = CMD_VALID & cmd_ready_q;
    assign pop_c    = fifo_valid & M_READY;
    assign land_c   = tag_vld_q[LAT-1];

    // Words still owed to the FIFO after this edge; a new read may only be
    // registered when room is guaranteed for its data.
    assign occ_c       = OW'(inflight_q) + OW'(re_q) + OW'(fifo_count) - OW'(pop_c);
    assign can_issue_c = (occ_c < OW'(RD_FIFO_DEPTH));

    // Control FSM with registered read-port and handshake outputs.
    always_ff @(posedge RCLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            re_q        <= 1'b0;
            last_q      <= 1'b0;
            raddr_q     <= '0;
            rem_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        // The pipe is empty here, so the first read goes out at once.
                        state_q     <= ST_READ;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        re_q        <= 1'b1;
                        raddr_q     <= CMD_ADDR;
                        rem_q       <= CMD_LEN;
                        last_q      <= (CMD_LEN == '0);
                    end else begin
                        cmd_ready_q <= 1'b1;
                        re_q        <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (re_q && last_q) begin
                        state_q <= ST_DRAIN;
                        re_q    <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (can_issue_c && (rem_q != '0)) begin
                        re_q    <= 1'b1;
                        raddr_q <= raddr_q + AW'(1);
                        rem_q   <= rem_q - LW'(1);
                        last_q  <= (rem_q == LW'(1));
                    end else begin
                        re_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    re_q <= 1'b0;
                    if (pop_c && fifo_head[DW]) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    re_q        <= 1'b0;
                end
            endcase
        end
    end

    // LAST tag pipe matching the RAM latency, plus the in-flight read count.
    always_ff @(posedge RCLK) begin
        if (RST) begin
            tag_vld_q  <= '0;
            tag_last_q <= '0;
            inflight_q <= '0;
        end else begin
            tag_vld_q[0]  <= re_q;
            tag_last_q[0] <= re_q & last_q;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
            inflight_q <= inflight_q + CW'(re_q) - CW'(land_c);
        end
    end

    bram_sdp_read_streamer_skid_fifo #(
        .WIDTH (DW + 1)
    ) u_fifo (
        .clk      (RCLK),
        .rst      (RST),
        .wr_en    (land_c),
        .wr_data  ({tag_last_q[LAT-1], RDATA}),
        .rd_en    (M_READY),
        .rd_valid (fifo_valid),
        .rd_data  (fifo_head),
        .count    (fifo_count)
    );

    assign CMD_READY = cmd_ready_q;
    assign BUSY      = busy_q;
    assign RE        = re_q;
    assign RADDREN   = re_q;
    assign RADDR     = raddr_q;
    assign M_VALID   = fifo_valid;
    assign M_DATA    = fifo_head[DW-1:0];
    assign M_LAST    = fifo_head[DW];

endmodule

// File: tb/tb_bram_sdp_read_streamer.sv
// Scoreboard bench: two streamers (RAM latency 1 and 2), each on its own RAM
// model holding word[a] = a ^ 16'hA5A5, exercised one after the other.
module tb_bram_sdp_read_streamer;

    localparam int DW = 16;
    localparam int AW = 9;
    localparam int LW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_valid [2];
    logic          cmd_ready [2];
    logic [AW-1:0] cmd_addr  [2];
    logic [LW-1:0] cmd_len   [2];
    logic          re        [2];
    logic          raddren   [2];
    logic [AW-1:0] raddr     [2];
    logic [DW-1:0] rdata     [2];
    logic          m_valid   [2];
    logic          m_ready   [2];
    logic [DW-1:0] m_data    [2];
    logic          m_last    [2];
    logic          busy      [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] mem_q;
        logic [DW-1:0] pipe_q;

        bram_sdp_read_streamer #(
            .READ_DATA_WIDTH    (DW),
            .READ_ADDRESS_WIDTH (AW),
            .OUTPUT_REG         (g),
            .LEN_WIDTH          (LW)
        ) u_dut (
            .RCLK      (clk),
            .RST       (rst),
            .CMD_VALID (cmd_valid[g]),
            .CMD_READY (cmd_ready[g]),
            .CMD_ADDR  (cmd_addr[g]),
            .CMD_LEN   (cmd_len[g]),
            .RE        (re[g]),
            .RADDREN   (raddren[g]),
            .RADDR     (raddr[g]),
            .RDATA     (rdata[g]),
            .M_VALID   (m_valid[g]),
            .M_READY   (m_ready[g]),
            .M_DATA    (m_data[g]),
            .M_LAST    (m_last[g]),
            .BUSY      (busy[g])
        );

        // RAM read port model with optional output register.
        always @(posedge clk) begin
            if (re[g] && raddren[g]) mem_q <= DW'(raddr[g]) ^ 16'hA5A5;
            pipe_q <= mem_q;
        end
        assign rdata[g] = (g == 0) ? mem_q : pipe_q;
    end

    int checks = 0;
    int errors = 0;
    int sel = 0;
    int rdy_mode = 0;
    int beats = 0;
    logic [DW:0]   exp_q  [$];
    logic [AW-1:0] addr_q [$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, sel, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream and address sequence straight from the command.
    task automatic push_exp(input int a, input int l);
        logic [AW-1:0] ad;
        for (int i = 0; i <= l; i++) begin
            ad = AW'(a + i);
            exp_q.push_back({(i == l), DW'(ad) ^ 16'hA5A5});
            addr_q.push_back(ad);
        end
    endtask

    // Returns in the cycle right after the accepting edge.
    task automatic issue(input int a, input int l);
        int ok;
        push_exp(a, l);
        cmd_valid[sel] = 1'b1;
        cmd_addr[sel]  = AW'(a);
        cmd_len[sel]   = LW'(l);
        ok = 0;
        for (int n = 0; n < 300; n++) begin
            if (cmd_ready[sel]) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (ok == 1) tick();
        cmd_valid[sel] = 1'b0;
        chk("cmd_accept_in_time", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((busy[sel] || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (busy[sel] || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s dut%0d: timeout busy=%0d words_left=%0d expected busy=0 words_left=0",
                     name, sel, busy[sel], exp_q.size());
        end
    endtask

    // Sink ready pattern generator.
    initial begin
        int k;
        k = 0;
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            k++;
            case (rdy_mode)
                0:       m_ready[sel] = 1'b1;
                1:       m_ready[sel] = ((k % 4) == 0) || ((k % 4) == 3);
                default: m_ready[sel] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: read-port order, outstanding cap, stall stability, beat scoreboard.
    initial begin
        logic          stall_prev;
        logic [DW-1:0] stall_data;
        logic          stall_last;
        logic [DW:0]   e;
        int            issued_cnt;
        int            popped_cnt;
        stall_prev = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;
        issued_cnt = 0;
        popped_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                issued_cnt = 0;
                popped_cnt = 0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid_held", 32'(m_valid[sel]), 32'd1);
                    chk("stall_data_held", 32'(m_data[sel]), 32'(stall_data));
                    chk("stall_last_held", 32'(m_last[sel]), 32'(stall_last));
                end
                if (re[sel]) begin
                    chk("raddren_eq_re", 32'(raddren[sel]), 32'd1);
                    chk("outstanding_below_4", 32'(issued_cnt - popped_cnt < 4), 32'd1);
                    if (addr_q.size() == 0) begin
                        chk("unexpected_read_issued", 32'd1, 32'd0);
                    end else begin
                        chk("raddr_sequence", 32'(raddr[sel]), 32'(addr_q.pop_front()));
                    end
                    issued_cnt++;
                end
                if (m_valid[sel] && m_ready[sel]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'(m_data[sel]), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 32'(m_data[sel]), 32'(e[DW-1:0]));
                        chk("beat_last", 32'(m_last[sel]), 32'(e[DW]));
                    end
                    popped_cnt++;
                    beats++;
                end
                stall_prev = m_valid[sel] && !m_ready[sel];
                stall_data = m_data[sel];
                stall_last = m_last[sel];
            end
        end
    end

    // Stimulus.
    initial begin
        int lat;
        int n;
        int b0;
        int first;
        int ok;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_addr[d]  = '0;
            cmd_len[d]   = '0;
        end

        for (int d = 0; d < 2; d++) begin
            sel = d;
            lat = d + 1;
            rdy_mode = 0;
            rst = 1'b1;
            exp_q.delete();
            addr_q.delete();
            repeat (3) tick();
            // Reset values.
            chk("rst_cmd_ready", 32'(cmd_ready[sel]), 32'd0);
            chk("rst_re", 32'(re[sel]), 32'd0);
            chk("rst_raddren", 32'(raddren[sel]), 32'd0);
            chk("rst_raddr", 32'(raddr[sel]), 32'd0);
            chk("rst_m_valid", 32'(m_valid[sel]), 32'd0);
            chk("rst_m_last", 32'(m_last[sel]), 32'd0);
            chk("rst_m_data", 32'(m_data[sel]), 32'd0);
            chk("rst_busy", 32'(busy[sel]), 32'd0);
            rst = 1'b0;
            tick();
            chk("idle_cmd_ready", 32'(cmd_ready[sel]), 32'd1);

            // T1: single word.
            issue(5, 0);
            chk("t1_re_cycle1", 32'(re[sel]), 32'd1);
            chk("t1_busy_cycle1", 32'(busy[sel]), 32'd1);
            chk("t1_cmd_ready_low", 32'(cmd_ready[sel]), 32'd0);
            n = 1;
            while (!m_valid[sel] && n < 20) begin
                tick();
                n++;
            end
            chk("t1_first_beat_cycle", 32'(n), 32'(2 + lat));
            chk("t1_data", 32'(m_data[sel]), 32'h0000_A5A0);
            chk("t1_last", 32'(m_last[sel]), 32'd1);
            tick();
            chk("t1_busy_after_pop", 32'(busy[sel]), 32'd0);
            chk("t1_cmd_ready_after_pop", 32'(cmd_ready[sel]), 32'd1);
            wait_idle("t1_idle", 20);

            // T2: eight-word burst at full rate.
            issue(10, 7);
            n = 1;
            while (!m_valid[sel] && n < 20) begin
                tick();
                n++;
            end
            chk("t2_first_beat_cycle", 32'(n), 32'(2 + lat));
            for (int k = 0; k < 8; k++) begin
                chk("t2_no_bubble", 32'(m_valid[sel]), 32'd1);
                chk("t2_last_position", 32'(m_last[sel]), 32'(k == 7));
                tick();
            end
            wait_idle("t2_idle", 40);

            // T4: address wrap.
            issue(510, 3);
            wait_idle("t4_idle", 40);

            // T6: command held during a burst is taken once, only after idle.
            b0 = beats;
            issue(30, 7);
            push_exp(200, 0);
            cmd_valid[sel] = 1'b1;
            cmd_addr[sel]  = AW'(200);
            cmd_len[sel]   = LW'(0);
            ok = 0;
            for (int k = 0; k < 60; k++) begin
                if (cmd_ready[sel]) begin
                    ok = 1;
                    break;
                end
                tick();
            end
            chk("t6_second_accept_in_time", 32'(ok), 32'd1);
            chk("t6_first_burst_done_before_accept", 32'(beats - b0), 32'd8);
            tick();
            chk("t6_ready_low_after_accept_c1", 32'(cmd_ready[sel]), 32'd0);
            tick();
            chk("t6_ready_low_after_accept_c2", 32'(cmd_ready[sel]), 32'd0);
            cmd_valid[sel] = 1'b0;
            wait_idle("t6_idle", 40);
            repeat (3) tick();
            chk("t6_total_beats", 32'(beats - b0), 32'd9);

            // T5: reset at the third beat.
            b0 = beats;
            issue(20, 7);
            n = 0;
            while ((beats - b0) < 2 && n < 40) begin
                tick();
                n++;
            end
            chk("t5_beat3_present", 32'(m_valid[sel]), 32'd1);
            rst = 1'b1;
            exp_q.delete();
            addr_q.delete();
            tick();
            rst = 1'b0;
            chk("t5_m_valid_after_rst", 32'(m_valid[sel]), 32'd0);
            chk("t5_busy_after_rst", 32'(busy[sel]), 32'd0);
            chk("t5_re_after_rst", 32'(re[sel]), 32'd0);
            chk("t5_cmd_ready_after_rst", 32'(cmd_ready[sel]), 32'd0);
            b0 = beats;
            issue(0, 1);
            wait_idle("t5_idle", 40);
            repeat (6) tick();
            chk("t5_beats_after_rst", 32'(beats - b0), 32'd2);

            // T3: back-pressure 1,0,0,1.
            rdy_mode = 1;
            issue(100, 15);
            wait_idle("t3_idle", 300);

            // Random commands under random back-pressure.
            rdy_mode = 2;
            for (int r = 0; r < 6; r++) begin
                issue(int'($urandom_range(0, 511)), int'($urandom_range(0, 24)));
                wait_idle("rand_idle", 600);
            end

            // Maximum length burst, wrapping the address space twice.
            rdy_mode = 0;
            issue(300, 1023);
            wait_idle("maxlen_idle", 1500);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
